// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, runs a variable-latency instruction-memory handshake and
// presents instr / pc+4 / valid to decode, inserting bubbles while memory
// is slow. A one-word buffer (HOLD) keeps a response that lands during a
// stall; DRAIN discards a response still in flight across a redirect.
//
// Optional feature (macro FETCH_PERF_CNT_EN): saturating perf counters
// perf_bubbles (bubbles caused by no available word) and perf_redirects.
//
//   state | meaning
//   REQ   | request outstanding at imem_addr = pc
//   HOLD  | no request; buffer holds one fetched word and its pc+4
//   DRAIN | request outstanding at a stale address; its response is dropped
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ir_write,
    input  logic        flush,
    input  logic        pc_src,
    input  logic        jmp,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_redirects
`endif
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        available;

    assign advance   = pc_write & ir_write;
    assign redirect  = pc_src | jmp;
    assign target    = jmp ? jump_target : branch_target;
    assign pc_plus4  = pc_q + 32'd4;
    assign available = ((state_q == ST_REQ) & imem_valid) | (state_q == ST_HOLD);

    // Request is suppressed while reset is held so memory never sees one.
    assign imem_req       = ~rst & (state_q != ST_HOLD);
    assign imem_addr      = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign fetch_busy     = ~available & ~redirect;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;

    // Next-state decode: redirect > flush > stall > normal.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        if (redirect) begin
            pc_d        = target;
            instr_d     = NOP_INSTR;
            pc4_d       = 32'd0;
            valid_d     = 1'b0;
            buf_instr_d = NOP_INSTR;
            buf_pc4_d   = 32'd0;
            if (imem_valid) begin
                state_d = ST_REQ;
            end else if (state_q == ST_REQ) begin
                state_d      = ST_DRAIN;
                drain_addr_d = pc_q;
            end else if (state_q == ST_DRAIN) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            // The in-flight response being waited for is dropped here.
            if ((state_q == ST_DRAIN) && imem_valid) begin
                state_d = ST_REQ;
            end
            if (flush) begin
                instr_d = NOP_INSTR;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
            end else if (!advance) begin
                if ((state_q == ST_REQ) && imem_valid) begin
                    buf_instr_d = imem_rdata;
                    buf_pc4_d   = pc_plus4;
                    state_d     = ST_HOLD;
                end
            end else if (available) begin
                instr_d = (state_q == ST_HOLD) ? buf_instr_q : imem_rdata;
                pc4_d   = (state_q == ST_HOLD) ? buf_pc4_q : pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
                state_d = ST_REQ;
            end else begin
                instr_d = NOP_INSTR;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
            end
        end
    end

    // State, PC, buffer and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= PC_RESET;
            drain_addr_q <= PC_RESET;
            buf_instr_q  <= NOP_INSTR;
            buf_pc4_q    <= 32'd0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubbles_q;
    logic [31:0] perf_redirects_q;
    logic        bubble_evt;

    assign bubble_evt     = ~redirect & ~flush & advance & ~available;
    assign perf_bubbles   = perf_bubbles_q;
    assign perf_redirects = perf_redirects_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubbles_q   <= 32'd0;
            perf_redirects_q <= 32'd0;
        end else begin
            if (bubble_evt && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
            if (redirect && (perf_redirects_q != 32'hFFFF_FFFF)) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end
`endif

endmodule
